// File: rtl/div_unit_ctrl.sv
// rtl/div_unit_ctrl.sv - RISC-V DIV/DIVU/REM/REMU sequencer around an external unsigned divider
// Handles sign magnitudes, divide-by-zero/overflow shortcuts and a fixed settle wait.
module div_unit_ctrl #(
  parameter int WAIT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_tag,
  output logic [31:0] o_div_dividend,
  output logic [31:0] o_div_divisor,
  input  logic [31:0] i_div_quotient,
  input  logic [31:0] i_div_remainder,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic [4:0]  o_tag
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        is_rem_q;
  logic        neg_q;
  logic        neg_r;

  logic        is_signed;
  logic        is_rem;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic        div_zero;
  logic        overflow;
  logic        special;
  logic [31:0] special_result;
  logic [31:0] final_result;
  logic        accept;

  // op[0]=0 selects the signed variants, op[1]=1 selects remainder
  always_comb begin
    is_signed      = ~i_op[0];
    is_rem         = i_op[1];
    mag1           = (is_signed && i_rs1[31]) ? (32'd0 - i_rs1) : i_rs1;
    mag2           = (is_signed && i_rs2[31]) ? (32'd0 - i_rs2) : i_rs2;
    div_zero       = (i_rs2 == 32'd0);
    overflow       = is_signed && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
    special        = div_zero || overflow;
    special_result = 32'd0;
    if (div_zero)
      special_result = is_rem ? i_rs1 : 32'hFFFF_FFFF;
    else
      special_result = is_rem ? 32'd0 : 32'h8000_0000;
  end

  always_comb begin
    final_result = 32'd0;
    if (is_rem_q)
      final_result = neg_r ? (32'd0 - i_div_remainder) : i_div_remainder;
    else
      final_result = neg_q ? (32'd0 - i_div_quotient) : i_div_quotient;
  end

  assign accept = i_valid && o_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      is_rem_q       <= 1'b0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      o_ready        <= 1'b1;
      o_valid        <= 1'b0;
      o_result       <= 32'd0;
      o_tag          <= 5'd0;
      o_div_dividend <= 32'd0;
      o_div_divisor  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_div_dividend <= mag1;
            o_div_divisor  <= mag2;
            o_tag          <= i_tag;
            is_rem_q       <= is_rem;
            neg_q          <= is_signed && (i_rs1[31] ^ i_rs2[31]);
            neg_r          <= is_signed && i_rs1[31];
            o_ready        <= 1'b0;
            if (special) begin
              o_result <= special_result;
              o_valid  <= 1'b1;
              state    <= DONE;
            end else begin
              cnt   <= CNT_LOAD;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            o_result <= final_result;
            o_valid  <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
